i2c_reg_seq: RTL and testbench

Transaction sequencer that drives the command interface of the I2C master (cmd/din/wr_i2c, ready/ack/dout). It turns one single-byte register write or register read request into the full I2C command sequence: START, address/data writes, RESTART, read, STOP. It sits between a requester (a slot-register bank or an internal FSM) and the I2C master, so software no longer issues each command by hand. The SCL divisor is programmed separately and is outside this block.

---
 rtl/i2c_reg_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_reg_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: expands one single-byte register write or read request into
// the full START / WR / RESTART / RD / STOP command sequence for the I2C
// master. It waits for master ready between commands, aborts to STOP on
// a NACK, and gives up after a bounded stall.
module i2c_reg_seq #(
   parameter int TIMEOUT_CYC = 100000,
   parameter int TMO_W       = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       rsp_tmo,
   output logic       busy,
   output logic [2:0] m_cmd,
   output logic [7:0] m_din,
   output logic       m_wr,
   input  logic       m_ready,
   input  logic       m_ack,
   input  logic [7:0] m_dout
);

   localparam logic [2:0] CMD_START   = 3'b000;
   localparam logic [2:0] CMD_WR      = 3'b001;
   localparam logic [2:0] CMD_RD      = 3'b010;
   localparam logic [2:0] CMD_STOP    = 3'b011;
   localparam logic [2:0] CMD_RESTART = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_SETTLE = 3'd2,
      S_WAIT   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [2:0]       step_reg, step_next;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic             rw_reg, rw_next;
   logic [6:0]       dev_reg, dev_next;
   logic [7:0]       addr_reg, addr_next;
   logic [7:0]       wdata_reg, wdata_next;
   logic [7:0]       rdata_reg, rdata_next;
   logic             nack_reg, nack_next;
   logic             tmo_reg, tmo_next;

   logic [2:0]       step_cmd;
   logic [7:0]       step_din;
   logic [2:0]       stop_step;
   logic             stalled;
   logic             tmo_hit;

   // Decode the command and data byte for the current step of the request
   always_comb begin
      step_cmd = CMD_STOP;
      step_din = 8'h00;
      case (step_reg)
         3'd0: step_cmd = CMD_START;
         3'd1: begin
            step_cmd = CMD_WR;
            step_din = {dev_reg, 1'b0};
         end
         3'd2: begin
            step_cmd = CMD_WR;
            step_din = addr_reg;
         end
         3'd3: begin
            if (rw_reg) begin
               step_cmd = CMD_RESTART;
            end else begin
               step_cmd = CMD_WR;
               step_din = wdata_reg;
            end
         end
         3'd4: begin
            if (rw_reg) begin
               step_cmd = CMD_WR;
               step_din = {dev_reg, 1'b1};
            end
         end
         3'd5: begin
            // Single-byte read: ask the master to NACK the only byte
            step_cmd = CMD_RD;
            step_din = 8'h01;
         end
         default: step_cmd = CMD_STOP;
      endcase
   end

   assign stop_step = rw_reg ? 3'd6 : 3'd4;
   assign stalled   = ((state_reg == S_ISSUE) || (state_reg == S_WAIT)) && !m_ready;
   // Fires on the stalled cycle that brings the count up to TIMEOUT_CYC
   assign tmo_hit   = (TIMEOUT_CYC != 0) && stalled &&
                      ((tmo_cnt_reg + TMO_W'(1)) == TMO_W'(TIMEOUT_CYC));

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= S_IDLE;
         step_reg    <= 3'd0;
         tmo_cnt_reg <= '0;
         rw_reg      <= 1'b0;
         dev_reg     <= 7'h00;
         addr_reg    <= 8'h00;
         wdata_reg   <= 8'h00;
         rdata_reg   <= 8'h00;
         nack_reg    <= 1'b0;
         tmo_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         step_reg    <= step_next;
         tmo_cnt_reg <= tmo_cnt_next;
         rw_reg      <= rw_next;
         dev_reg     <= dev_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         rdata_reg   <= rdata_next;
         nack_reg    <= nack_next;
         tmo_reg     <= tmo_next;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_next   = state_reg;
      step_next    = step_reg;
      tmo_cnt_next = tmo_cnt_reg;
      rw_next      = rw_reg;
      dev_next     = dev_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      rdata_next   = rdata_reg;
      nack_next    = nack_reg;
      tmo_next     = tmo_reg;
      case (state_reg)
         S_IDLE: begin
            tmo_cnt_next = '0;
            if (req_valid) begin
               rw_next    = req_rw;
               dev_next   = req_dev;
               addr_next  = req_reg;
               wdata_next = req_wdata;
               rdata_next = 8'h00;
               nack_next  = 1'b0;
               tmo_next   = 1'b0;
               step_next  = 3'd0;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (m_ready) begin
               tmo_cnt_next = '0;
               state_next   = S_SETTLE;
            end else if (tmo_hit) begin
               tmo_next   = 1'b1;
               state_next = S_RESP;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end
         S_SETTLE: state_next = S_WAIT;
         S_WAIT: begin
            if (m_ready) begin
               if ((step_cmd == CMD_WR) && m_ack) begin
                  nack_next  = 1'b1;
                  step_next  = stop_step;
                  state_next = S_ISSUE;
               end else if (step_cmd == CMD_STOP) begin
                  state_next = S_RESP;
               end else begin
                  if (step_cmd == CMD_RD) begin
                     rdata_next = m_dout;
                  end
                  step_next  = step_reg + 3'd1;
                  state_next = S_ISSUE;
               end
            end else if (tmo_hit) begin
               tmo_next   = 1'b1;
               state_next = S_RESP;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end
         S_RESP: begin
            nack_next  = 1'b0;
            tmo_next   = 1'b0;
            rdata_next = 8'h00;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state; the strobe follows m_ready combinationally
   always_comb begin
      req_ready = (state_reg == S_IDLE) && reset;
      busy      = (state_reg != S_IDLE);
      m_wr      = 1'b0;
      m_cmd     = 3'b000;
      m_din     = 8'h00;
      rsp_valid = 1'b0;
      rsp_rdata = 8'h00;
      rsp_nack  = 1'b0;
      rsp_tmo   = 1'b0;
      if ((state_reg == S_ISSUE) && m_ready) begin
         m_wr  = 1'b1;
         m_cmd = step_cmd;
         m_din = step_din;
      end
      if (state_reg == S_RESP) begin
         rsp_valid = 1'b1;
         rsp_tmo   = tmo_reg;
         rsp_nack  = nack_reg && !tmo_reg;
         rsp_rdata = (nack_reg || tmo_reg) ? 8'h00 : rdata_reg;
      end
   end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed testbench for i2c_reg_seq with a small behavioural I2C master model.
module tb_i2c_reg_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rw = 1'b0;
   logic [6:0] req_dev = 7'h00;
   logic [7:0] req_reg = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;
   logic       rsp_tmo;
   logic       busy;
   logic [2:0] m_cmd;
   logic [7:0] m_din;
   logic       m_wr;
   logic       m_ready = 1'b1;
   logic       m_ack = 1'b0;
   logic [7:0] m_dout = 8'h00;

   int checks = 0;
   int errors = 0;

   i2c_reg_seq #(.TIMEOUT_CYC(50), .TMO_W(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
      .rsp_tmo(rsp_tmo), .busy(busy),
      .m_cmd(m_cmd), .m_din(m_din), .m_wr(m_wr),
      .m_ready(m_ready), .m_ack(m_ack), .m_dout(m_dout)
   );

   always #5 clk = ~clk;

   // Master model state
   int          cyc = 0;
   bit          stall_start = 1'b0;
   bit          nack_en = 1'b0;
   logic [7:0]  nack_byte = 8'h00;
   logic [7:0]  rd_byte = 8'h00;
   int          dly = 0;
   logic [2:0]  pend_cmd = 3'b000;
   logic [7:0]  pend_din = 8'h00;
   logic [10:0] seq_q[$];
   int          wr_cyc_q[$];
   int          last_wr = -100;
   int          adj_err = 0;
   int          acc_q[$];
   int          rsp_cyc_q[$];
   int          rsp_cnt = 0;
   logic [7:0]  rsp_rdata_l = 8'h00;
   logic        rsp_nack_l = 1'b0;
   logic        rsp_tmo_l = 1'b0;

   // Master: drops ready after each strobe, returns it with ack/data later
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_wr) begin
         seq_q.push_back({m_cmd, m_din});
         wr_cyc_q.push_back(cyc);
         if (cyc - last_wr < 3) adj_err <= adj_err + 1;
         last_wr  <= cyc;
         m_ready  <= 1'b0;
         m_ack    <= 1'b0;
         dly      <= 3;
         pend_cmd <= m_cmd;
         pend_din <= m_din;
      end else if (!m_ready) begin
         if (dly > 0) begin
            dly <= dly - 1;
         end else if (!(stall_start && pend_cmd == 3'b000)) begin
            m_ready <= 1'b1;
            m_ack   <= nack_en && (pend_cmd == 3'b001) && (pend_din == nack_byte);
            if (pend_cmd == 3'b010) m_dout <= rd_byte;
         end
      end
   end

   // Record accepts and responses
   always @(posedge clk) begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (rsp_valid) begin
         rsp_cyc_q.push_back(cyc);
         rsp_cnt     <= rsp_cnt + 1;
         rsp_rdata_l <= rsp_rdata;
         rsp_nack_l  <= rsp_nack;
         rsp_tmo_l   <= rsp_tmo;
      end
   end

   task automatic prep();
      for (int i = 0; i < 200 && !m_ready; i++) @(negedge clk);
      @(negedge clk);
      seq_q.delete();
      wr_cyc_q.delete();
      acc_q.delete();
      rsp_cyc_q.delete();
   endtask

   task automatic send(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd);
      @(negedge clk);
      req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
      req_valid = 1'b1;
      for (int i = 0; i < 500 && !req_ready; i++) @(negedge clk);
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL accept: req_ready=%b required 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      for (int i = 0; i < 3000 && rsp_cnt < target; i++) @(negedge clk);
      checks++;
      if (rsp_cnt < target) begin
         errors++;
         $display("FAIL rsp_wait: rsp_cnt=%0d required %0d", rsp_cnt, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (m_wr !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: m_wr=%b busy=%b rsp_valid=%b required 0 0 0", m_wr, busy, rsp_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
      end
      checks++;
      if ({m_cmd, m_din, rsp_rdata, rsp_nack, rsp_tmo} !== 21'h0) begin
         errors++;
         $display("FAIL reset_outs: cmd=%h din=%h rdata=%h nack=%b tmo=%b required all 0",
                  m_cmd, m_din, rsp_rdata, rsp_nack, rsp_tmo);
      end
      $display("txn reset: req_ready=%b busy=%b", req_ready, busy);
   endtask

   task automatic test_write();
      logic [10:0] exp[5];
      int n0;
      exp = '{{3'b000, 8'h00}, {3'b001, 8'hA0}, {3'b001, 8'h10}, {3'b001, 8'hA5}, {3'b011, 8'h00}};
      prep();
      n0 = rsp_cnt;
      send(1'b0, 7'h50, 8'h10, 8'hA5);
      wait_rsp(n0 + 1);
      checks++;
      if (seq_q.size() != 5) begin
         errors++;
         $display("FAIL write_len: got %0d commands required 5", seq_q.size());
      end
      for (int i = 0; i < 5 && i < seq_q.size(); i++) begin
         checks++;
         if (seq_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL write_cmd%0d: got %h required %h", i, seq_q[i], exp[i]);
         end
      end
      checks++;
      if (rsp_nack_l !== 1'b0 || rsp_tmo_l !== 1'b0 || rsp_rdata_l !== 8'h00) begin
         errors++;
         $display("FAIL write_rsp: nack=%b tmo=%b rdata=%h required 0 0 00", rsp_nack_l, rsp_tmo_l, rsp_rdata_l);
      end
      $display("txn write dev=50 reg=10 wdata=A5: cmds=%0d nack=%b tmo=%b", seq_q.size(), rsp_nack_l, rsp_tmo_l);
   endtask

   task automatic test_read();
      logic [10:0] exp[7];
      int n0;
      exp = '{{3'b000, 8'h00}, {3'b001, 8'hA0}, {3'b001, 8'h20}, {3'b100, 8'h00},
              {3'b001, 8'hA1}, {3'b010, 8'h01}, {3'b011, 8'h00}};
      prep();
      rd_byte = 8'h3C;
      n0 = rsp_cnt;
      send(1'b1, 7'h50, 8'h20, 8'hFF);
      wait_rsp(n0 + 1);
      checks++;
      if (seq_q.size() != 7) begin
         errors++;
         $display("FAIL read_len: got %0d commands required 7", seq_q.size());
      end
      for (int i = 0; i < 7 && i < seq_q.size(); i++) begin
         checks++;
         if (seq_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL read_cmd%0d: got %h required %h", i, seq_q[i], exp[i]);
         end
      end
      checks++;
      if (rsp_rdata_l !== 8'h3C || rsp_nack_l !== 1'b0 || rsp_tmo_l !== 1'b0) begin
         errors++;
         $display("FAIL read_rsp: rdata=%h nack=%b tmo=%b required 3C 0 0", rsp_rdata_l, rsp_nack_l, rsp_tmo_l);
      end
      $display("txn read dev=50 reg=20: rdata=%h nack=%b", rsp_rdata_l, rsp_nack_l);
   endtask

   task automatic test_nack();
      logic [10:0] exp[3];
      int n0;
      exp = '{{3'b000, 8'h00}, {3'b001, 8'hA0}, {3'b011, 8'h00}};
      prep();
      rd_byte = 8'h3C;
      nack_en = 1'b1;
      nack_byte = 8'hA0;
      n0 = rsp_cnt;
      send(1'b1, 7'h50, 8'h20, 8'h00);
      wait_rsp(n0 + 1);
      nack_en = 1'b0;
      checks++;
      if (seq_q.size() != 3) begin
         errors++;
         $display("FAIL nack_len: got %0d commands required 3", seq_q.size());
      end
      for (int i = 0; i < 3 && i < seq_q.size(); i++) begin
         checks++;
         if (seq_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL nack_cmd%0d: got %h required %h", i, seq_q[i], exp[i]);
         end
      end
      checks++;
      if (rsp_nack_l !== 1'b1 || rsp_tmo_l !== 1'b0 || rsp_rdata_l !== 8'h00) begin
         errors++;
         $display("FAIL nack_rsp: nack=%b tmo=%b rdata=%h required 1 0 00", rsp_nack_l, rsp_tmo_l, rsp_rdata_l);
      end
      $display("txn read-nack dev=50: cmds=%0d nack=%b", seq_q.size(), rsp_nack_l);
   endtask

   task automatic test_timeout();
      int n0;
      int gap;
      prep();
      stall_start = 1'b1;
      n0 = rsp_cnt;
      send(1'b0, 7'h50, 8'h10, 8'hA5);
      wait_rsp(n0 + 1);
      stall_start = 1'b0;
      checks++;
      if (rsp_tmo_l !== 1'b1 || rsp_nack_l !== 1'b0 || rsp_rdata_l !== 8'h00) begin
         errors++;
         $display("FAIL tmo_rsp: tmo=%b nack=%b rdata=%h required 1 0 00", rsp_tmo_l, rsp_nack_l, rsp_rdata_l);
      end
      gap = (rsp_cyc_q.size() > 0 && wr_cyc_q.size() > 0) ? rsp_cyc_q[0] - wr_cyc_q[0] : -1;
      // strobe, one settle cycle, 50 stalled wait cycles, then the response
      checks++;
      if (gap != 52) begin
         errors++;
         $display("FAIL tmo_gap: got %0d cycles required 52", gap);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (seq_q.size() != 1) begin
         errors++;
         $display("FAIL tmo_nostop: got %0d commands required 1", seq_q.size());
      end
      $display("txn write-timeout: tmo=%b gap=%0d", rsp_tmo_l, gap);
   endtask

   task automatic test_reset_mid();
      int n0;
      prep();
      n0 = rsp_cnt;
      send(1'b1, 7'h50, 8'h20, 8'h00);
      for (int i = 0; i < 500 && seq_q.size() < 5; i++) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_wr, m_cmd, m_din, rsp_valid, rsp_rdata, rsp_nack, rsp_tmo, busy} !== 23'h0) begin
         errors++;
         $display("FAIL midrst_outs: wr=%b cmd=%h din=%h rv=%b rd=%h nk=%b tmo=%b busy=%b required all 0",
                  m_wr, m_cmd, m_din, rsp_valid, rsp_rdata, rsp_nack, rsp_tmo, busy);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_ready: req_ready=%b required 1", req_ready);
      end
      repeat (30) @(negedge clk);
      checks++;
      if (rsp_cnt != n0 || seq_q.size() != 5) begin
         errors++;
         $display("FAIL midrst_quiet: rsp=%0d cmds=%0d required %0d 5", rsp_cnt, seq_q.size(), n0);
      end
      $display("txn read-reset: cmds=%0d responses=%0d", seq_q.size(), rsp_cnt - n0);
   endtask

   task automatic test_back_to_back();
      int n0;
      int d;
      prep();
      rd_byte = 8'h5A;
      n0 = rsp_cnt;
      @(negedge clk);
      req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h10; req_wdata = 8'hA5;
      req_valid = 1'b1;
      for (int i = 0; i < 500 && !req_ready; i++) @(negedge clk);
      @(negedge clk);
      // second request queued immediately, valid never drops
      req_rw = 1'b1; req_dev = 7'h50; req_reg = 8'h20; req_wdata = 8'h00;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_busy: req_ready=%b required 0", req_ready);
      end
      for (int i = 0; i < 2000 && acc_q.size() < 2; i++) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(n0 + 2);
      d = (acc_q.size() >= 2 && rsp_cyc_q.size() >= 1) ? acc_q[1] - rsp_cyc_q[0] : -1;
      checks++;
      if (d != 1) begin
         errors++;
         $display("FAIL b2b_spacing: accept-rsp gap %0d required 1", d);
      end
      checks++;
      if (seq_q.size() != 12 || (seq_q.size() > 3 && seq_q[3] !== {3'b001, 8'hA5})) begin
         errors++;
         $display("FAIL b2b_cmds: got %0d commands required 12 with first data A5", seq_q.size());
      end
      checks++;
      if (rsp_rdata_l !== 8'h5A) begin
         errors++;
         $display("FAIL b2b_rdata: got %h required 5A", rsp_rdata_l);
      end
      checks++;
      if (adj_err != 0) begin
         errors++;
         $display("FAIL strobe_spacing: %0d close strobe pairs required 0", adj_err);
      end
      $display("txn back-to-back: accepts=%0d gap=%0d rdata=%h", acc_q.size(), d, rsp_rdata_l);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
